// File: rtl/cal_rom_sequencer.sv
// cal_rom_sequencer
// Walks the calibration config ROM from a start strobe. Each entry is
// {burst length, instruction, address}. The sequencer fetches an entry from the
// registered-read ROM and issues it as a burst of command beats over a
// valid/ready interface. It stops at an OP_END entry, or after the last ROM entry.
//
// Optional build macro: CAL_ROM_SEQ_JUMP_EN
//   Defined  : OP_JUMP entries redirect the ROM pointer without issuing beats.
//              A target >= DEPTH ends the program. A run of 16 jumps with no
//              beat in between also ends it, so a jump loop cannot hang.
//   Undefined: OP_JUMP is an ordinary instruction.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i             start strobe, sampled only in IDLE
//   abort_i             abandon the program and return to IDLE (highest priority)
//   rom_addr_o          registered ROM read address
//   rom_data_i          ROM word, valid one cycle after rom_addr_o
//   cmd_valid_o/ready_i beat handshake toward the calibration executor
//   cmd_instr_o         instruction of the current beat
//   cmd_addr_o          entry address + beat index (wraps)
//   cmd_last_o          final beat of the entry
//   busy_o              not IDLE
//   done_o              one-cycle pulse on program completion (not on abort)
module cal_rom_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int DEPTH          = 64,
  parameter int BL_WIDTH       = 8,
  parameter int INSTR_WIDTH    = 8,
  parameter int CMD_ADDR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] OP_END  = 8'hFF,
  parameter logic [INSTR_WIDTH-1:0] OP_JUMP = 8'hFE
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic [ADDR_WIDTH-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0]     rom_data_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [INSTR_WIDTH-1:0]    cmd_instr_o,
  output logic [CMD_ADDR_WIDTH-1:0] cmd_addr_o,
  output logic                      cmd_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     rom_addr_q;
  logic [BL_WIDTH-1:0]       beat_q;      // beat index within the entry
  logic [BL_WIDTH-1:0]       last_idx_q;  // eff_bl - 1
  logic                      cmd_valid_q;
  logic                      cmd_last_q;
  logic [INSTR_WIDTH-1:0]    cmd_instr_q;
  logic [CMD_ADDR_WIDTH-1:0] cmd_addr_q;
  logic                      done_q;

  // Field decode of the ROM word presented during LOAD.
  logic [BL_WIDTH-1:0]       ld_bl;
  logic [INSTR_WIDTH-1:0]    ld_instr;
  logic [CMD_ADDR_WIDTH-1:0] ld_addr;
  logic [BL_WIDTH-1:0]       ld_last_idx;

  assign ld_bl    = rom_data_i[DATA_WIDTH-1 -: BL_WIDTH];
  assign ld_instr = rom_data_i[CMD_ADDR_WIDTH +: INSTR_WIDTH];
  assign ld_addr  = rom_data_i[CMD_ADDR_WIDTH-1:0];
  // A stored burst length of 0 behaves as 1, so the last index is 0 either way.
  assign ld_last_idx = (ld_bl == '0) ? '0 : ld_bl - BL_WIDTH'(1);

  logic [BL_WIDTH-1:0]       beat_d;
  logic [CMD_ADDR_WIDTH-1:0] cmd_addr_d;
  logic [ADDR_WIDTH-1:0]     rom_addr_d;
  logic                      hs;

  assign beat_d     = beat_q + BL_WIDTH'(1);
  assign cmd_addr_d = cmd_addr_q + CMD_ADDR_WIDTH'(1);  // modulo 2**CMD_ADDR_WIDTH
  assign rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
  assign hs         = cmd_valid_q & cmd_ready_i;

`ifdef CAL_ROM_SEQ_JUMP_EN
  logic [3:0]            jmp_cnt_q;  // jumps since the last accepted beat
  logic [ADDR_WIDTH-1:0] ld_tgt;
  assign ld_tgt = ld_addr[ADDR_WIDTH-1:0];
`else
  logic unused_op_jump;
  assign unused_op_jump = ^OP_JUMP;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      beat_q      <= '0;
      last_idx_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      cmd_instr_q <= '0;
      cmd_addr_q  <= '0;
      done_q      <= 1'b0;
`ifdef CAL_ROM_SEQ_JUMP_EN
      jmp_cnt_q   <= '0;
`endif
    end else if (abort_i) begin
      // Abort wins over everything, including a start in IDLE. A beat handshaking
      // in this cycle has already been taken by the executor. Nothing to undo.
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            rom_addr_q <= '0;
            state_q    <= S_FETCH;
`ifdef CAL_ROM_SEQ_JUMP_EN
            jmp_cnt_q  <= '0;
`endif
          end
        end

        // rom_addr_q is stable here. The ROM registers the word at this edge.
        S_FETCH: state_q <= S_LOAD;

        S_LOAD: begin
          cmd_instr_q <= ld_instr;
          cmd_addr_q  <= ld_addr;
          last_idx_q  <= ld_last_idx;
          beat_q      <= '0;
          if (ld_instr == OP_END) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
`ifdef CAL_ROM_SEQ_JUMP_EN
          else if (ld_instr == OP_JUMP) begin
            if ((int'(ld_tgt) >= DEPTH) || (jmp_cnt_q == 4'hF)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              rom_addr_q <= ld_tgt;
              jmp_cnt_q  <= jmp_cnt_q + 4'd1;
              state_q    <= S_FETCH;
            end
          end
`endif
          else begin
            cmd_valid_q <= 1'b1;
            cmd_last_q  <= (ld_last_idx == '0);
            state_q     <= S_ISSUE;
          end
        end

        // Without a handshake no register changes, so the beat is held stable.
        S_ISSUE: begin
          if (hs) begin
`ifdef CAL_ROM_SEQ_JUMP_EN
            jmp_cnt_q <= '0;
`endif
            if (cmd_last_q) begin
              cmd_valid_q <= 1'b0;
              cmd_last_q  <= 1'b0;
              if (rom_addr_q == LAST_ADDR) begin
                // ROM exhausted. The pointer stays at the last entry.
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                rom_addr_q <= rom_addr_d;
                state_q    <= S_FETCH;
              end
            end else begin
              beat_q     <= beat_d;
              cmd_addr_q <= cmd_addr_d;
              cmd_last_q <= (beat_d == last_idx_q);
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
          cmd_last_q  <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_instr_o = cmd_instr_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_last_o  = cmd_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_cal_rom_sequencer.sv
// Bench for cal_rom_sequencer. The reference model walks the ROM image using the
// program rules. It produces the expected beat list, the cycle at which each
// entry's first beat appears, and the cycle of the done pulse.
module tb_cal_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start_i, abort_i, cmd_ready_i;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        cmd_valid, cmd_last, busy, done;
  logic [7:0]  cmd_instr;
  logic [15:0] cmd_addr;

  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  cal_rom_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready_i),
    .cmd_instr_o(cmd_instr), .cmd_addr_o(cmd_addr), .cmd_last_o(cmd_last),
    .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [7:0]  instr;
    logic [15:0] addr;
    logic        last;
    int          lead;  // first beat of an entry: cycles after prior last beat (or start)
  } beat_t;

  beat_t exp_q[$];
  int    end_lead;
  bit    exhausted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] v;
    v = 8'($urandom);
    while (v == 8'hFF || v == 8'hFE) v = 8'($urandom);
    return v;
  endfunction

  task automatic fill_end();
    for (int i = 0; i < 64; i++) mem[i] = 32'h00FF0000;
  endtask

  task automatic rand_prog();
    int n;
    fill_end();
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++)
      mem[i] = {8'($urandom_range(0, 4)), rand_instr(), 16'($urandom)};
  endtask

  // Reference model: walk the program and list every beat the executor should see.
  task automatic build_model();
    int          a, jc, n;
    logic [31:0] w;
    beat_t       b;
    a = 0; jc = 0;
    exp_q.delete();
    exhausted = 0;
    end_lead  = 3;
    for (int guard = 0; guard < 4096; guard++) begin
      w = mem[a];
      if (w[23:16] == 8'hFF) begin
        end_lead = 3 + 2 * jc;
        return;
      end
`ifdef CAL_ROM_SEQ_JUMP_EN
      if (w[23:16] == 8'hFE) begin
        jc++;
        if (jc == 16 || int'(w[5:0]) >= 64) begin
          end_lead = 2 * jc + 1;
          return;
        end
        a = int'(w[5:0]);
        continue;
      end
`endif
      n = (w[31:24] == 8'd0) ? 1 : int'(w[31:24]);
      for (int k = 0; k < n; k++) begin
        b.instr = w[23:16];
        b.addr  = w[15:0] + 16'(k);
        b.last  = (k == n - 1);
        b.lead  = (k == 0) ? 3 + 2 * jc : 0;
        exp_q.push_back(b);
      end
      jc = 0;
      if (a == 63) begin
        end_lead  = 1;
        exhausted = 1;
        return;
      end
      a++;
    end
  endtask

  // mode 0: ready always high, 1: ready toggles, 2: random ready plus stray starts while busy
  task automatic run_prog(input int mode, input string tag);
    int    cyc, nv, dc;
    bit    v, r;
    beat_t f;
    build_model();
    cyc = 0;
    nv  = (exp_q.size() > 0) ? exp_q[0].lead : 0;
    dc  = (exp_q.size() > 0) ? 32'h3FFF_FFFF : end_lead;
    @(negedge clk);
    start_i = 1'b1;
    cmd_ready_i = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start_i = (mode == 2 && cyc <= dc) ? 1'($urandom % 2) : 1'b0;
      if (cyc == 1) check({tag, ":rom_addr_start"}, 32'(rom_addr), 32'd0);
      v = (exp_q.size() > 0) && (cyc >= nv);
      check({tag, ":valid"}, 32'(cmd_valid), 32'(v));
      if (v) begin
        f = exp_q[0];
        check({tag, ":instr"}, 32'(cmd_instr), 32'(f.instr));
        check({tag, ":addr"},  32'(cmd_addr),  32'(f.addr));
        check({tag, ":last"},  32'(cmd_last),  32'(f.last));
      end
      check({tag, ":done"}, 32'(done), 32'(cyc == dc));
      check({tag, ":busy"}, 32'(busy), 32'(cyc <= dc));
      if (cyc == dc && exhausted) check({tag, ":rom_addr_end"}, 32'(rom_addr), 32'd63);
      if (cyc == dc + 1) break;
      if (cyc > 20000) begin
        check({tag, ":timeout"}, 32'd1, 32'd0);
        break;
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom % 2);
      cmd_ready_i = r;
      if (v && r) begin
        f = exp_q.pop_front();
        if (f.last) begin
          if (exp_q.size() > 0) nv = cyc + exp_q[0].lead;
          else                  dc = cyc + end_lead;
        end
      end
    end
    start_i = 1'b0;
    cmd_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cmd_ready_i = 1'b0;
    fill_end();
    repeat (3) @(negedge clk);
    check("rst:valid", 32'(cmd_valid), 32'd0);
    check("rst:last",  32'(cmd_last),  32'd0);
    check("rst:done",  32'(done),      32'd0);
    check("rst:busy",  32'(busy),      32'd0);
    check("rst:rom_addr", 32'(rom_addr), 32'd0);
    check("rst:instr", 32'(cmd_instr), 32'd0);
    check("rst:addr",  32'(cmd_addr),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed programs
    fill_end(); mem[0] = 32'h03100100; run_prog(0, "single");
    fill_end(); mem[0] = 32'h0022FFFF; run_prog(0, "zero_bl");
    fill_end(); mem[0] = 32'h0233FFFF; run_prog(0, "wrap");
    fill_end(); mem[0] = 32'h03100100; run_prog(1, "bp_single");
    rand_prog(); run_prog(0, "multi");
    run_prog(1, "multi_bp");

    // ROM exhaustion: no END anywhere
    for (int i = 0; i < 64; i++) mem[i] = {8'h01, rand_instr(), 16'($urandom)};
    run_prog(0, "exhaust");

    // OP_JUMP at entry 0 pointing at itself
    fill_end(); mem[0] = 32'h00FE0000; run_prog(0, "op_jump");

    // Random programs with random backpressure and stray starts
    repeat (6) begin
      rand_prog();
      run_prog(2, "random");
    end

    // Abort during the 2nd beat of a 4-beat burst with ready low
    fill_end(); mem[0] = 32'h04440200; mem[1] = 32'h01550300;
    @(negedge clk); start_i = 1'b1; cmd_ready_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort:beat1_valid", 32'(cmd_valid), 32'd1);
    check("abort:beat1_addr",  32'(cmd_addr),  32'h0200);
    @(negedge clk);
    check("abort:beat2_valid", 32'(cmd_valid), 32'd1);
    check("abort:beat2_addr",  32'(cmd_addr),  32'h0201);
    cmd_ready_i = 1'b0; abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    check("abort:valid", 32'(cmd_valid), 32'd0);
    check("abort:busy",  32'(busy),      32'd0);
    check("abort:done",  32'(done),      32'd0);
    @(negedge clk);
    check("abort:done_later", 32'(done), 32'd0);
    run_prog(0, "restart");

    // start together with abort in IDLE: stays idle
    @(negedge clk); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk); start_i = 1'b0; abort_i = 1'b0;
    check("start_abort:busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_abort:busy_later", 32'(busy), 32'd0);

    // Reset in the middle of a burst
    fill_end(); mem[0] = 32'h04440200;
    @(negedge clk); start_i = 1'b1; cmd_ready_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst:valid_before", 32'(cmd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst:valid", 32'(cmd_valid), 32'd0);
    check("midrst:busy",  32'(busy),      32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_prog(0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cal_rom_sequencer.md
Name: cal_rom_sequencer

Overview:
- Consumer of the calibration config ROM. It fetches entries of the form {burst length, instruction, address} from the registered-read ROM, decodes them, and issues each one as a burst of command beats over a valid/ready interface to the calibration datapath.
- It sits between the config ROM and the calibration command executor, and steps through the ROM program from a start strobe until an END entry is reached or the ROM is exhausted.

Parameters:
- DATA_WIDTH, 32, ROM word width; must equal BL_WIDTH+INSTR_WIDTH+CMD_ADDR_WIDTH
- ADDR_WIDTH, 6, ROM address width
- DEPTH, 64, number of ROM entries; 2**ADDR_WIDTH >= DEPTH
- BL_WIDTH, 8, burst-length field, word bits [31:24]
- INSTR_WIDTH, 8, instruction field, word bits [23:16]
- CMD_ADDR_WIDTH, 16, address field, word bits [15:0]
- OP_END, 8'hFF, opcode that terminates the program
- OP_JUMP, 8'hFE, jump opcode (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  start strobe; sampled only in IDLE
- abort_i  in  1  abort the program; return to IDLE
- rom_addr_o  out  ADDR_WIDTH  ROM read address (registered)
- rom_data_i  in  DATA_WIDTH  ROM read data, valid 1 cycle after rom_addr_o
- cmd_valid_o  out  1  command beat valid
- cmd_ready_i  in  1  executor accepts the beat
- cmd_instr_o  out  INSTR_WIDTH  instruction of the current beat
- cmd_addr_o  out  CMD_ADDR_WIDTH  address of the current beat
- cmd_last_o  out  1  marks the final beat of the entry
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when the program completes

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and all pointers and counters are 0.
- State machine: IDLE -> FETCH -> LOAD -> ISSUE -> (FETCH | DONE) -> IDLE.
- IDLE:
  - If start_i=1, go to FETCH and set rom_addr_o=0.
  - done_o=0.
- FETCH: a single cycle in which rom_addr_o is stable. The ROM registers the word at the end of this cycle.
- LOAD: capture rom_data_i into bl, instr and addr.
  - If instr==OP_END, go to DONE without issuing a beat.
  - Otherwise go to ISSUE with beat counter=0. A stored bl of 0 is treated as 1.
- ISSUE:
  - cmd_valid_o=1.
  - cmd_addr_o = addr + beat counter, wrapping modulo 2**CMD_ADDR_WIDTH.
  - cmd_last_o=1 when the beat counter equals eff_bl-1.
  - Outputs are held stable while cmd_valid_o=1 and cmd_ready_i=0.
  - Beat handshake is cmd_valid_o & cmd_ready_i; each handshake increments the beat counter.
  - On the handshake of the last beat:
    - If rom_addr_o==DEPTH-1, go to DONE (ROM exhausted).
    - Otherwise increment rom_addr_o and go to FETCH.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency: start_i sampled at cycle 0 gives FETCH at cycle 1, LOAD at cycle 2, and the first cmd_valid_o at cycle 3. Each subsequent entry adds 2 cycles of fetch overhead.
- cmd_valid_o is never asserted outside ISSUE, and beats are never issued in IDLE, FETCH or LOAD.
- start_i while busy_o=1: ignored.
- abort_i:
  - Takes priority over all other events, in any non-IDLE state.
  - Next cycle: IDLE, cmd_valid_o=0, no done_o pulse.
  - An abort in the same cycle as a beat handshake still counts that beat as accepted by the executor.
- start_i and abort_i together in IDLE: abort wins and the block stays in IDLE.
- Mid-operation reset: all state clears immediately (asynchronous reset), and cmd_valid_o drops without a handshake.
- rom_addr_o is registered and never changes during FETCH or LOAD.

Optional Feature:
- Macro: CAL_ROM_SEQ_JUMP_EN.
- Defined:
  - A LOAD with instr==OP_JUMP sets rom_addr_o = addr[ADDR_WIDTH-1:0] and goes to FETCH, issuing no beat.
  - A jump target >= DEPTH goes to DONE.
  - A 4-bit jump counter counts jumps taken. On the 16th consecutive jump without an intervening beat, go to DONE (runaway-loop guard).
- Undefined: OP_JUMP is an ordinary instruction and is issued as beats like any other opcode.

Test Plan:
- Single entry: MEM0=32'h03_10_0100 and MEM1=32'h00_FF_0000, cmd_ready_i=1, start pulse at cycle 0 -> cmd_valid_o at cycles 3-5, cmd_addr_o=0x0100/0x0101/0x0102, cmd_last_o only on the 3rd beat, done_o pulse 3 cycles after the last beat, no beat for the END entry.
- Zero-length burst: MEM0=32'h00_22_FFFF, MEM1=END -> exactly one beat, addr 0xFFFF, cmd_last_o=1. Also, bl=2 at addr 0xFFFF -> second beat addr wraps to 0x0000.
- Backpressure: cmd_ready_i toggles 0/1 every cycle -> outputs held stable while stalled, beat count and addresses unchanged versus the no-stall case.
- ROM exhaustion: no END present, all 64 entries bl=1 -> 64 beats, the last from rom_addr 63, then a done_o pulse, rom_addr_o does not wrap to 0.
- Abort during the 2nd beat of a 4-beat burst with cmd_ready_i=0 -> next cycle IDLE, busy_o=0, cmd_valid_o=0, no done_o; a new start restarts from rom_addr 0.
- With CAL_ROM_SEQ_JUMP_EN: MEM0=32'h00_FE_0000 (jump to self) -> no beats, done_o after the 16th jump. Without the macro, the same ROM gives one beat with cmd_instr_o=0xFE.
